// File: rtl/tetris_pkg.sv
// tetris_pkg: state type, default score limits and the line-clear point table
package tetris_pkg;

    typedef enum logic [2:0] {IDLE, PLAY, ADD, WIN, LOSE} score_state_t;

    localparam logic [6:0] WIN_SCORE = 7'd30;
    localparam logic [6:0] SCORE_MAX = 7'd99;

    function automatic logic [3:0] points(input logic [2:0] count);
        return count == 3'd1 ? 4'd1 :
               count == 3'd2 ? 4'd3 :
               count == 3'd3 ? 4'd5 :
               count == 3'd4 ? 4'd8 : 4'd0;
    endfunction

endpackage

// File: rtl/score_keeper_sat_add.sv
// sat_add: unsigned adder whose result is clamped to a ceiling
module sat_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] limit,
    output logic [W-1:0] sum
);

    logic [W:0] full;

    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full > {1'b0, limit} ? limit : full[W-1:0];

endmodule

// File: rtl/score_keeper.sv
// score_keeper: converts accepted line-clear events into score, lines and level,
// decides win/lose and holds the session high score for the UI.
module score_keeper #(
    parameter logic [6:0] WIN_SCORE       = tetris_pkg::WIN_SCORE,
    parameter logic [6:0] SCORE_MAX       = tetris_pkg::SCORE_MAX,
    parameter logic [3:0] LINES_PER_LEVEL = 4'd10,
    parameter logic [3:0] MAX_LEVEL       = 4'd9
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Game_Start,
    input  logic       Clear_Valid,
    input  logic [2:0] Clear_Count,
    output logic       Clear_Ready,
    input  logic       Top_Out,
    output logic [6:0] Score,
    output logic [6:0] Highest,
    output logic [7:0] Lines,
    output logic [3:0] Level,
    output logic       Playing,
    output logic       Win,
    output logic       Lose
);

    import tetris_pkg::*;

    score_state_t state, state_nxt;
    logic [2:0]   count;
    logic [7:0]   score_sum, lines_sum, level_raw;
    logic [3:0]   level_nxt;
    logic         take;

    assign take = Clear_Valid && Clear_Ready;

    // score is summed at 8 bits so a carry past 7 bits still saturates
    sat_add #(.W(8)) u_score (
        .a     ({1'b0, Score}),
        .b     ({4'd0, points(count)}),
        .limit ({1'b0, SCORE_MAX}),
        .sum   (score_sum)
    );

    sat_add #(.W(8)) u_lines (
        .a     (Lines),
        .b     ({5'd0, count}),
        .limit (8'd255),
        .sum   (lines_sum)
    );

    assign level_raw = lines_sum / {4'd0, LINES_PER_LEVEL};
    assign level_nxt = level_raw > {4'd0, MAX_LEVEL} ? MAX_LEVEL : level_raw[3:0];

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (Game_Start)         state_nxt = PLAY;
        else if (state == PLAY) state_nxt = Top_Out ? LOSE : take ? ADD : PLAY;
        else if (state == ADD)  state_nxt = Top_Out ? LOSE : score_sum >= {1'b0, WIN_SCORE} ? WIN : PLAY;
    end

    always_comb begin
        Playing     = state == PLAY || state == ADD;
        Win         = state == WIN;
        Lose        = state == LOSE;
        Clear_Ready = state == PLAY && !Top_Out && !Game_Start;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Score   <= '0;
            Highest <= '0;
            Lines   <= '0;
            Level   <= '0;
            count   <= '0;
        end else begin
            if (Score > Highest) Highest <= Score;
            if (take) count <= Clear_Count > 3'd4 ? 3'd4 : Clear_Count;
            if (Game_Start) begin
                Score <= '0;
                Lines <= '0;
                Level <= '0;
            end else if (state == ADD) begin
                Score <= score_sum[6:0];
                Lines <= lines_sum;
                Level <= level_nxt;
            end
        end
    end

endmodule
